// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch conditioner.
package sw_pkg;

   localparam int N_CH_DEFAULT         = 4;
   localparam int DEBOUNCE_10MS_100MHZ = 1000000;
   localparam int DEBOUNCE_SIM         = 4;
   localparam int CNT_W_DEFAULT        = 20;

endpackage

// File: rtl/sw_debounce_ch.sv
// One debounce channel: accepts a synchronised level only after it has
// disagreed with the current stable level for DEBOUNCE_CYCLES consecutive cycles.
module debounce_ch
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic din_sync,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Acceptance resets the counter on the same edge, so it never reaches wrap.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (din_sync == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt    <= '0;
            stable <= din_sync;
            rise   <= din_sync;
            fall   <= ~din_sync;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: 2-flop synchroniser, per-channel debounce, edge
// pulses and a latched change event with a valid/ack handshake.
module sw_debounce
   import sw_pkg::*;
#(
   parameter int N_CH            = N_CH_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter int CNT_W           = CNT_W_DEFAULT
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] sw_stable,
   output logic [N_CH-1:0] sw_rise,
   output logic [N_CH-1:0] sw_fall,
   output logic            evt_valid,
   output logic [N_CH-1:0] evt_state,
   output logic [N_CH-1:0] evt_rise_mask,
   output logic [N_CH-1:0] evt_fall_mask,
   output logic            evt_ovf,
   input  logic            evt_ack
);

   logic [N_CH-1:0] sync_s1;
   logic [N_CH-1:0] sync_s2;
   logic            any_edge;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= sw;
         sync_s2 <= sync_s1;
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .CLK      (CLK),
         .RST_N    (RST_N),
         .din_sync (sync_s2[ch]),
         .stable   (sw_stable[ch]),
         .rise     (sw_rise[ch]),
         .fall     (sw_fall[ch])
      );
   end

   assign any_edge = |(sw_rise | sw_fall);

   // A new edge always wins over a same-cycle ack, so no change is ever lost.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         evt_valid     <= 1'b0;
         evt_state     <= '0;
         evt_rise_mask <= '0;
         evt_fall_mask <= '0;
         evt_ovf       <= 1'b0;
      end else if (any_edge) begin
         evt_valid <= 1'b1;
         evt_state <= sw_stable;
         evt_ovf   <= evt_valid && !evt_ack;
         if (!evt_valid || evt_ack) begin
            evt_rise_mask <= sw_rise;
            evt_fall_mask <= sw_fall;
         end else begin
            evt_rise_mask <= evt_rise_mask | sw_rise;
            evt_fall_mask <= evt_fall_mask | sw_fall;
         end
      end else if (evt_valid && evt_ack) begin
         evt_valid     <= 1'b0;
         evt_rise_mask <= '0;
         evt_fall_mask <= '0;
         evt_ovf       <= 1'b0;
      end
   end

endmodule
